// File: rtl/ro_freq_meter.sv
// rtl/ro_freq_meter.sv - ring-oscillator frequency meter: settle, gated edge count, saturating result
module ro_freq_meter #(
    parameter int COUNT_W       = 32,
    parameter int GATE_W        = 24,
    parameter int GATE_CYCLES   = 1000000,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               ro_in,
    output logic               ro_enable,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] count,
    output logic               overflow
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [GATE_W-1:0]  GATE_LOAD   = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GATE_W-1:0]  SETTLE_LOAD = GATE_W'(SETTLE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] ACC_MAX     = '1;

    state_t              state;
    logic [GATE_W-1:0]   timer;
    logic [COUNT_W-1:0]  acc;
    logic                sat;
    logic [COUNT_W-1:0]  acc_nxt;
    logic                sat_nxt;
    logic                s1, s2, s3;
    logic                rise;

    // Bring ro_in into the clk domain and keep one extra stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= ro_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Saturating accumulate of this cycle's rising edge; sat latches once an edge is lost
    always_comb begin
        acc_nxt = acc;
        sat_nxt = sat;
        if (rise) begin
            if (acc == ACC_MAX) begin
                sat_nxt = 1'b1;
            end else begin
                acc_nxt = acc + 1'b1;
            end
        end
    end

    // Measurement sequencer; the result is published on the GATE->DONE transition
    // so count/overflow are already valid in the cycle done is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            timer     <= '0;
            acc       <= '0;
            sat       <= 1'b0;
            ro_enable <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SETTLE;
                        timer     <= SETTLE_LOAD;
                        acc       <= '0;
                        sat       <= 1'b0;
                        ro_enable <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (timer == '0) begin
                        state <= ST_GATE;
                        timer <= GATE_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_GATE: begin
                    acc <= acc_nxt;
                    sat <= sat_nxt;
                    if (timer == '0) begin
                        state     <= ST_DONE;
                        count     <= acc_nxt;
                        overflow  <= sat_nxt;
                        done      <= 1'b1;
                        ro_enable <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb/tb_ro_freq_meter.sv - randomized self-checking bench for ro_freq_meter
module tb_ro_freq_meter;

    localparam int S  = 4;
    localparam int G  = 100;
    localparam int SG = S + G;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        ro_in = 1'b0;

    logic        en_a, busy_a, done_a, ovf_a;
    logic [31:0] cnt_a;
    logic        en_b, busy_b, done_b, ovf_b;
    logic [3:0]  cnt_b;

    int n_checks = 0;
    int n_err    = 0;

    int ro_mode = 0;
    int ro_half = 5;
    int ro_ph   = 0;

    int cyc = -1;
    bit samp [0:32767];

    ro_freq_meter #(.COUNT_W(32), .GATE_W(24), .GATE_CYCLES(G), .SETTLE_CYCLES(S)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .ro_in(ro_in),
        .ro_enable(en_a), .busy(busy_a), .done(done_a), .count(cnt_a), .overflow(ovf_a)
    );

    ro_freq_meter #(.COUNT_W(4), .GATE_W(24), .GATE_CYCLES(G), .SETTLE_CYCLES(S)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .ro_in(ro_in),
        .ro_enable(en_b), .busy(busy_b), .done(done_b), .count(cnt_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    // record the ro_in level seen at every rising edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        samp[cyc] = ro_in;
    end

    // oscillator stand-in, changes away from the sampling edge
    always @(negedge clk) begin
        ro_ph = ro_ph + 1;
        case (ro_mode)
            0: ro_in = 1'b0;
            1: ro_in = 1'b1;
            2: if (ro_ph >= ro_half) begin ro_in = ~ro_in; ro_ph = 0; end
            default: ro_in = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // edges the meter should report for a start seen at edge e0: 0->1 transitions of
    // the sampled input between edges e0+S-1 and e0+S+G-2, clipped to the counter range
    task automatic model(input int e0, input int w, output longint c, output longint ov);
        longint raw = 0;
        longint mx  = (longint'(1) << w) - 1;
        for (int j = e0 + S - 1; j <= e0 + SG - 2; j++) begin
            if (samp[j] && !samp[j-1]) raw++;
        end
        c  = (raw > mx) ? mx : raw;
        ov = (raw > mx) ? 1 : 0;
    endtask

    // one measurement on DUT sel (0: 32-bit, 1: 4-bit); optional stray starts mid-run
    task automatic run_meas(input int sel, input bit repulse);
        int e0;
        longint ec, eo, held;
        logic en, bz, dn;
        longint cn, ov;
        @(negedge clk);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        e0 = cyc + 1;
        held = 0;
        for (int k = 1; k <= SG + 2; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            if (repulse && (k == 2 || k == S + 10 || k == SG + 1)) begin
                if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
            end
            en = sel ? en_b : en_a;
            bz = sel ? busy_b : busy_a;
            dn = sel ? done_b : done_a;
            cn = sel ? longint'(cnt_b) : longint'(cnt_a);
            ov = sel ? longint'(ovf_b) : longint'(ovf_a);
            if (en !== (k <= SG)) check_val("ro_enable", en, (k <= SG));
            if (bz !== (k <= SG)) check_val("busy", bz, (k <= SG));
            if (dn !== (k == SG + 1)) check_val("done", dn, (k == SG + 1));
            if (k == S) check_val("en_settle", en, 1);
            if (k == SG + 1) begin
                model(e0, sel ? 4 : 32, ec, eo);
                check_val("count", cn, ec);
                check_val("overflow", ov, eo);
                check_val("done_pulse", dn, 1);
                held = cn;
            end
            if (k == SG + 2) begin
                check_val("count_hold", cn, held);
                check_val("en_after", en, 0);
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        // the stray start in DONE must not launch another run
        repeat (3) begin
            @(negedge clk);
            en = sel ? en_b : en_a;
            if (en !== 1'b0) check_val("no_requeue", en, 0);
        end
    endtask

    initial begin
        int e0;
        int dq[$];
        longint ec, eo, last;

        // reset values
        repeat (3) @(negedge clk);
        check_val("rst_en", en_a, 0);
        check_val("rst_busy", busy_a, 0);
        check_val("rst_done", done_a, 0);
        check_val("rst_count", cnt_a, 0);
        check_val("rst_ovf", ovf_a, 0);
        check_val("rst_count_b", cnt_b, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // constant input, both levels
        ro_mode = 0; run_meas(0, 0);
        ro_mode = 1; run_meas(0, 0);

        // period 10 clk
        ro_mode = 2; ro_half = 5; run_meas(0, 0);

        // narrow counter: saturate, then in range
        ro_half = 2;  run_meas(1, 0);
        ro_half = 10; run_meas(1, 0);

        // random periods and random bit streams
        for (int i = 0; i < 4; i++) begin
            ro_mode = 2; ro_half = int'($urandom_range(1, 12));
            run_meas(i % 2, 0);
            ro_mode = 3;
            run_meas(i % 2, 0);
        end

        // stray starts in SETTLE, GATE and DONE, then a fresh run
        ro_mode = 2; ro_half = 5;
        run_meas(0, 1);
        run_meas(0, 0);

        // reset in GATE cycle 50
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (S + 49) @(negedge clk);
        check_val("pre_rst_en", en_a, 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_en", en_a, 0);
        check_val("mid_rst_busy", busy_a, 0);
        check_val("mid_rst_count", cnt_a, 0);
        repeat (SG) begin
            @(negedge clk);
            if (done_a !== 1'b0) check_val("mid_rst_done", done_a, 0);
        end
        rst_n = 1'b1;
        run_meas(0, 0);

        // start held high: repeating measurements every S+G+2 cycles
        ro_mode = 3;
        @(negedge clk);
        start_a = 1'b1;
        e0 = cyc + 1;
        last = -1;
        for (int k = 0; k < 3 * (SG + 2) + 5; k++) begin
            @(negedge clk);
            if (done_a) begin
                model(e0 + dq.size() * (SG + 2), 32, ec, eo);
                check_val("held_count", cnt_a, ec);
                dq.push_back(cyc);
                last = cnt_a;
            end else if (last >= 0 && longint'(cnt_a) !== last) begin
                check_val("held_stable", cnt_a, last);
            end
        end
        start_a = 1'b0;
        check_val("held_ndone", dq.size(), 3);
        if (dq.size() == 3) begin
            check_val("held_first", dq[0], e0 + SG);
            check_val("held_gap1", dq[1] - dq[0], SG + 2);
            check_val("held_gap2", dq[2] - dq[1], SG + 2);
        end
        repeat (SG + 4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
